// File: rtl/mc_resp_tx.sv
// Completion transmit path: queues MC-core completions and serialises them
// as header/data beats on the host response link.
module mc_resp_tx #(
  parameter int DEPTH = 4,
  parameter int AW    = 64,
  parameter int DW    = 64
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cmp_valid,
  output logic          cmp_ready,
  input  logic [1:0]    cmp_type,
  input  logic [2:0]    cmp_ptr,
  input  logic [AW-1:0] cmp_addr,
  input  logic [DW-1:0] cmp_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [1:0]    rsp_cmd,
  output logic [2:0]    rsp_tag,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_last,
  output logic [7:0]    err_cnt
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t state;

  logic [1:0]    type_q [DEPTH];
  logic [2:0]    ptr_q  [DEPTH];
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr, rd_nxt, ld_idx;
  logic [PW:0]   count;
  logic          legal, push, bad, pop, more;

  assign cmp_ready = (count != (PW+1)'(DEPTH));
  assign legal     = (cmp_type == 2'd1) || (cmp_type == 2'd2);
  assign push      = cmp_valid && cmp_ready && legal;
  assign bad       = cmp_valid && cmp_ready && !legal;

  // A response retires on its last beat: the header of a write ack, or the data beat of a read.
  assign pop    = rsp_valid && rsp_ready &&
                  (((state == HDR) && (rsp_cmd == 2'd1)) || (state == DATA));
  assign more   = (count > (PW+1)'(1));
  assign rd_nxt = rd_ptr + PW'(1);
  assign ld_idx = (state == IDLE) ? rd_ptr : rd_nxt;

  always_ff @(posedge clk) begin
    if (push) begin
      type_q[wr_ptr] <= cmp_type;
      ptr_q[wr_ptr]  <= cmp_ptr;
      addr_q[wr_ptr] <= cmp_addr;
      data_q[wr_ptr] <= cmp_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_nxt;
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_cnt <= '0;
    end else if (bad && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  // Next header comes from the entry behind the one being popped, so back-to-back responses have no bubble.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_cmd   <= '0;
      rsp_tag   <= '0;
      rsp_data  <= '0;
      rsp_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            state     <= HDR;
            rsp_valid <= 1'b1;
            rsp_cmd   <= type_q[ld_idx];
            rsp_tag   <= ptr_q[ld_idx];
            rsp_data  <= DW'(addr_q[ld_idx]);
            rsp_last  <= (type_q[ld_idx] == 2'd1);
          end
        end
        HDR, DATA: begin
          if (rsp_ready) begin
            if ((state == HDR) && (rsp_cmd != 2'd1)) begin
              state    <= DATA;
              rsp_data <= data_q[rd_ptr];
              rsp_last <= 1'b1;
            end else if (more) begin
              state     <= HDR;
              rsp_valid <= 1'b1;
              rsp_cmd   <= type_q[ld_idx];
              rsp_tag   <= ptr_q[ld_idx];
              rsp_data  <= DW'(addr_q[ld_idx]);
              rsp_last  <= (type_q[ld_idx] == 2'd1);
            end else begin
              state     <= IDLE;
              rsp_valid <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
